// File: rtl/activation_pipe.sv
// Two-stage per-lane activation (bypass / ReLU / leaky ReLU / clamp) with a row-count pass FSM.
// Optional: define ACTIVATION_NEG_COUNT_EN to add the neg_count output (negative valid-lane element counter).

module activation_lane #(
  parameter int DWIDTH = 8,
  parameter int SHW    = 3
) (
  input  logic [DWIDTH-1:0] i_x,
  input  logic              i_valid,
  input  logic [1:0]        i_mode,
  input  logic [SHW-1:0]    i_shift,
  input  logic [DWIDTH-1:0] i_clamp,
  output logic [DWIDTH-1:0] o_y
);
  logic signed [DWIDTH-1:0] w_x, w_c;
  logic                     w_neg;

  assign w_x   = i_x;
  assign w_c   = i_clamp;
  assign w_neg = i_x[DWIDTH-1];

  always_comb begin
    o_y = i_x;
    case (i_mode)
      2'b01: if (w_neg) o_y = '0;
      2'b10: if (w_neg) o_y = w_x >>> i_shift;
      2'b11: begin
        if (w_neg)           o_y = '0;
        else if (w_x > w_c)  o_y = i_clamp;
      end
      default: ;
    endcase
    if (!i_valid) o_y = '0;
  end
endmodule

module activation_pipe #(
  parameter int NUM_LANES     = 4,
  parameter int DWIDTH        = 8,
  parameter int MASK_WIDTH    = NUM_LANES,
  parameter int ROW_CNT_WIDTH = 16,
  localparam int SHW          = $clog2(DWIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_activation,
  input  logic [1:0]                     mode,
  input  logic [SHW-1:0]                 leak_shift,
  input  logic [DWIDTH-1:0]              clamp_max,
  input  logic [ROW_CNT_WIDTH-1:0]       num_rows,
  input  logic                           in_data_available,
  input  logic [NUM_LANES*DWIDTH-1:0]    inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [NUM_LANES*DWIDTH-1:0]    out_data,
  output logic                           out_data_available,
  output logic                           done_activation,
  output logic [ROW_CNT_WIDTH-1:0]       rows_done
`ifdef ACTIVATION_NEG_COUNT_EN
  ,
  output logic [ROW_CNT_WIDTH-1:0]       neg_count
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;
  logic   w_start, w_abort, w_accept;

  logic [1:0]               r_mode;
  logic [SHW-1:0]           r_leak_shift;
  logic [DWIDTH-1:0]        r_clamp_max;
  logic [ROW_CNT_WIDTH-1:0] r_num_rows, r_acc_cnt, r_rows_done;
  logic                     r_done;

  // [1] = stage-1 row valid, [2] = output valid
  logic [2:1]                          r_vld_pipe;
  logic [NUM_LANES-1:0][DWIDTH-1:0]    r_s1_data, w_act, r_out;
  logic [MASK_WIDTH-1:0]               r_s1_mask;

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_abort  = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (enable_activation) begin
        w_start = 1'b1;
        w_next  = (num_rows != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (!enable_activation) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (in_data_available) begin
          w_accept = 1'b1;
          if (r_acc_cnt + ROW_CNT_WIDTH'(1) == r_num_rows) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!enable_activation) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (!r_vld_pipe[1]) begin
          // stage 2 empties on this same edge, so DONE follows the final output by one cycle
          w_next = S_DONE;
        end
      end
      S_DONE: if (!enable_activation) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    activation_lane #(.DWIDTH(DWIDTH), .SHW(SHW)) u_lane (
      .i_x     (r_s1_data[i]),
      .i_valid (r_s1_mask[i]),
      .i_mode  (r_mode),
      .i_shift (r_leak_shift),
      .i_clamp (r_clamp_max),
      .o_y     (w_act[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mode       <= '0;
      r_leak_shift <= '0;
      r_clamp_max  <= '0;
      r_num_rows   <= '0;
      r_acc_cnt    <= '0;
      r_rows_done  <= '0;
      r_done       <= 1'b0;
      r_vld_pipe   <= '0;
      r_s1_data    <= '0;
      r_s1_mask    <= '0;
      r_out        <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      if (w_start) begin
        r_mode       <= mode;
        r_leak_shift <= leak_shift;
        r_clamp_max  <= clamp_max;
        r_num_rows   <= num_rows;
      end
      if (w_start || w_abort)  r_acc_cnt <= '0;
      else if (w_accept)       r_acc_cnt <= r_acc_cnt + ROW_CNT_WIDTH'(1);
      if (w_start || w_abort)  r_rows_done <= '0;
      else if (r_vld_pipe[2])  r_rows_done <= r_rows_done + ROW_CNT_WIDTH'(1);
      r_vld_pipe[1] <= w_accept;
      r_vld_pipe[2] <= r_vld_pipe[1] && !w_abort;
      if (w_accept) begin
        r_s1_data <= inp_data;
        r_s1_mask <= validity_mask;
      end
      if (r_vld_pipe[1] && !w_abort) r_out <= w_act;
    end
  end

  assign out_data           = r_out;
  assign out_data_available = r_vld_pipe[2];
  assign done_activation    = r_done;
  assign rows_done          = r_rows_done;

`ifdef ACTIVATION_NEG_COUNT_EN
  logic [ROW_CNT_WIDTH-1:0] r_neg;
  logic [ROW_CNT_WIDTH:0]   w_neg_add, w_neg_sum;

  always_comb begin
    w_neg_add = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_neg_add = w_neg_add + (ROW_CNT_WIDTH+1)'(r_s1_data[i][DWIDTH-1] & r_s1_mask[i]);
    w_neg_sum = {1'b0, r_neg} + w_neg_add;
  end

  always_ff @(posedge clk) begin
    if (reset || w_start || w_abort) r_neg <= '0;
    else if (r_vld_pipe[1])          r_neg <= w_neg_sum[ROW_CNT_WIDTH] ? '1 : w_neg_sum[ROW_CNT_WIDTH-1:0];
  end

  assign neg_count = r_neg;
`endif
endmodule
